// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory access sequencer placed behind the multicycle control FSM. It takes
//   the memory_read / memory_write / ir_write / lorD strobes, picks the address
//   (pc_in or alu_out_in), runs a req/ack access on a variable-latency bus and
//   captures read data into IR or MDR. stall holds the core while the access
//   is outstanding.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   memory_read/_write  access strobes from the control FSM (write wins)
//   ir_write            read data destination: 1 = IR, 0 = MDR
//   lorD                address select: 0 = pc_in, 1 = alu_out_in
//   pc_in, alu_out_in   address sources
//   write_data_in       store data
//   stall               freeze request to the core
//   instr_out, mdr_out  IR and MDR contents
//   bus_req/_we/_addr/_wdata, bus_ack, bus_rdata   memory bus
//   bus_error           sticky error (misaligned address or timeout)
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Bus handshake: bus_req is high only in WAIT, and bus_addr / bus_we /
// bus_wdata are stable while it is high. The access completes on the first
// cycle in which bus_ack is sampled high with bus_req high; bus_rdata is
// valid in that same cycle. bus_ack outside WAIT has no effect.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic                  ir_write,
  input  logic                  lorD,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [ADDR_WIDTH-1:0] alu_out_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_error,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter value of the last WAIT cycle before the access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic                  dest_ir_q, dest_ir_d;
  logic                  bus_error_q, bus_error_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic                  req_seen;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    dest_ir_d   = dest_ir_q;
    bus_error_d = bus_error_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    req_seen    = memory_read | memory_write;
    addr_sel    = lorD ? alu_out_in : pc_in;

    case (state_q)
      ST_IDLE: begin
        if (req_seen) begin
          bus_addr_d  = addr_sel;
          bus_wdata_d = write_data_in;
          // A write never captures data, even if ir_write is also set.
          dest_ir_d   = ir_write & ~memory_write;
          cnt_d       = 8'd0;
          if (addr_sel[1:0] != 2'b00) begin
            // Misaligned: flag it and finish without touching the bus.
            bus_error_d = 1'b1;
            bus_we_d    = 1'b0;
            state_d     = ST_DONE;
          end else begin
            bus_we_d  = memory_write;
            bus_req_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Ack is checked first so an ack in the timeout cycle still counts.
        if (bus_ack) begin
          if (!bus_we_q) begin
            if (dest_ir_q) ir_d = bus_rdata;
            else           mdr_d = bus_rdata;
          end
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          bus_error_d = 1'b1;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // Strobes still high here belong to the finished access.
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      dest_ir_q   <= 1'b0;
      bus_error_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      dest_ir_q   <= dest_ir_d;
      bus_error_q <= bus_error_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
    end
  end

  // stall rises combinationally in the request cycle so the control FSM
  // does not advance past the memory state before the access is latched.
  assign stall     = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & req_seen);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign instr_out = ir_q;
  assign mdr_out   = mdr_q;
  assign bus_error = bus_error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 8). Each access
//   is predicted at transaction level: number of stall cycles, number of bus
//   request cycles, bus fields, IR/MDR contents and the sticky error flag.
module tb_mem_access_unit;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk;
  logic          rst_n;
  logic          memory_read;
  logic          memory_write;
  logic          ir_write;
  logic          lorD;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] alu_out_in;
  logic [DW-1:0] write_data_in;
  logic          stall;
  logic [DW-1:0] instr_out;
  logic [DW-1:0] mdr_out;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          bus_error;
  logic [1:0]    dbg_state;

  mem_access_unit #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .memory_read   (memory_read),
    .memory_write  (memory_write),
    .ir_write      (ir_write),
    .lorD          (lorD),
    .pc_in         (pc_in),
    .alu_out_in    (alu_out_in),
    .write_data_in (write_data_in),
    .stall         (stall),
    .instr_out     (instr_out),
    .mdr_out       (mdr_out),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .bus_error     (bus_error),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_ir  = '0;
  logic [DW-1:0] exp_mdr = '0;
  logic          exp_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver + model for one access ----------------
  // ack_delay: WAIT cycle (1-based) in which bus_ack is driven; 0 = never.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic irw, input logic lord,
                           input logic [AW-1:0] pc, input logic [AW-1:0] alu,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rdata,
                           input int ack_delay);
    logic [AW-1:0] eff;
    logic          mis;
    int            exp_wait;
    int            stall_cnt;
    int            req_cnt;
    logic          finished;
    logic          addr_ok, we_ok, wd_ok;

    // transaction-level prediction
    eff = lord ? alu : pc;
    mis = (eff % 4) != 0;
    if (mis) begin
      exp_wait = 0;
      exp_err  = 1'b1;
    end else if (ack_delay >= 1 && ack_delay <= TMO) begin
      exp_wait = ack_delay;
      if (!wr) begin
        if (irw) exp_ir  = rdata;
        else     exp_mdr = rdata;
      end
    end else begin
      exp_wait = TMO;
      exp_err  = 1'b1;
    end

    @(posedge clk); #1;
    memory_read   = rd;
    memory_write  = wr;
    ir_write      = irw;
    lorD          = lord;
    pc_in         = pc;
    alu_out_in    = alu;
    write_data_in = wd;

    stall_cnt = 0;
    req_cnt   = 0;
    finished  = 1'b0;
    addr_ok   = 1'b1;
    we_ok     = 1'b1;
    wd_ok     = 1'b1;
    for (int c = 0; c < 40 && !finished; c++) begin
      if (bus_req) begin
        req_cnt++;
        if (bus_addr  !== eff) addr_ok = 1'b0;
        if (bus_we    !== wr)  we_ok   = 1'b0;
        if (bus_wdata !== wd)  wd_ok   = 1'b0;
        bus_ack   = (req_cnt == ack_delay);
        bus_rdata = (req_cnt == ack_delay) ? rdata : $urandom;
      end else begin
        // ack outside WAIT must have no effect
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      else       finished = 1'b1;
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    check_val({tag, "_completed"}, 32'(finished), 32'd1);
    check_val({tag, "_stall_cycles"}, stall_cnt, 1 + exp_wait);
    check_val({tag, "_req_cycles"}, req_cnt, exp_wait);
    check_val({tag, "_addr_stable"}, 32'(addr_ok), 32'd1);
    check_val({tag, "_we_stable"}, 32'(we_ok), 32'd1);
    check_val({tag, "_wdata_stable"}, 32'(wd_ok), 32'd1);

    // DONE cycle: strobes are still high and must be ignored
    @(posedge clk); #1;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    bus_ack      = 1'b0;
    @(negedge clk);
    check_val({tag, "_idle_stall"}, 32'(stall), 32'd0);
    check_val({tag, "_idle_req"}, 32'(bus_req), 32'd0);
    check_val({tag, "_ir"}, instr_out, exp_ir);
    check_val({tag, "_mdr"}, mdr_out, exp_mdr);
    check_val({tag, "_error"}, 32'(bus_error), 32'(exp_err));
  endtask

  task automatic random_access(input int idx);
    int            kind;
    logic [AW-1:0] a;
    kind = $urandom_range(0, 2);       // 0 read, 1 write, 2 both (write wins)
    a    = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    do_access($sformatf("rnd%0d", idx), kind != 1, kind != 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFFC, a, $urandom, $urandom,
              $urandom_range(0, TMO + 2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    memory_read = 1'b0; memory_write = 1'b0; ir_write = 1'b0; lorD = 1'b0;
    pc_in = '0; alu_out_in = '0; write_data_in = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #12;
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_req", 32'(bus_req), 32'd0);
    check_val("rst_we", 32'(bus_we), 32'd0);
    check_val("rst_addr", bus_addr, 32'd0);
    check_val("rst_wdata", bus_wdata, 32'd0);
    check_val("rst_ir", instr_out, 32'd0);
    check_val("rst_mdr", mdr_out, 32'd0);
    check_val("rst_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fetch, ack in first WAIT cycle
    do_access("fetch", 1, 0, 1, 0, 32'h10, 32'h0, 32'h0, 32'h0050_0093, 1);
    // load into MDR with 4 WAIT cycles
    do_access("load", 1, 0, 0, 1, 32'h14, 32'h100, 32'h0, 32'hDEAD_BEEF, 4);
    // store
    do_access("store", 0, 1, 0, 1, 32'h18, 32'h200, 32'h1234_5678, 32'hFFFF_FFFF, 3);
    // ack in the final allowed WAIT cycle is honoured
    do_access("ack_last", 1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'hA5A5_0001, TMO);
    // timeout, then error stays set across good accesses
    do_access("timeout", 1, 0, 1, 1, 32'h24, 32'h300, 32'h0, 32'h1111_2222, 0);
    do_access("after_tmo", 1, 0, 1, 0, 32'h28, 32'h0, 32'h0, 32'h3333_4444, 2);
    // misaligned
    do_access("misalign", 1, 0, 0, 1, 32'h2C, 32'h102, 32'h0, 32'h5555_6666, 1);
    // both strobes: write wins, no capture
    do_access("rd_wr", 1, 1, 1, 0, 32'h30, 32'h0, 32'hCAFE_F00D, 32'h7777_8888, 2);

    for (int i = 0; i < 30; i++) random_access(i);

    // reset while in WAIT
    @(posedge clk); #1;
    memory_read = 1'b1; ir_write = 1'b1; lorD = 1'b0; pc_in = 32'h40;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    check_val("rstw_req_before", 32'(bus_req), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    memory_read = 1'b0;
    #1;
    check_val("rstw_req", 32'(bus_req), 32'd0);
    check_val("rstw_ir", instr_out, 32'd0);
    check_val("rstw_mdr", mdr_out, 32'd0);
    check_val("rstw_error", 32'(bus_error), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("rstw_idle_stall", 32'(stall), 32'd0);
    check_val("rstw_idle_req", 32'(bus_req), 32'd0);
    check_val("rstw_idle_ir", instr_out, 32'd0);
    check_val("rstw_idle_mdr", mdr_out, 32'd0);
    exp_ir = '0; exp_mdr = '0; exp_err = 1'b0;

    for (int i = 30; i < 40; i++) random_access(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global guard so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
